key_debounce: RTL

- Conditions a raw board push-button (KEY0) into clean control signals for the timer/counter stages that follow it.
- Provides a two-flop synchroniser and a debounce state machine.
- Outputs:
  - single-cycle press and release pulses
  - a long-press pulse
  - a toggling `run` level that drives counter enables directly.
- Sits between the board pin and any counter block gated by a key.

---
 rtl/bk_key_pkg.sv | 16 +
 rtl/sync_2ff.sv | 33 +++
 rtl/key_debounce.sv | 155 +++++++++++++++
 3 files changed

// File: rtl/bk_key_pkg.sv
// Shared definitions for the board-key conditioning blocks: debounce FSM
// state encoding and default cycle counts for a 100 MHz system clock.
`timescale 1ns/1ps
package bk_key_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        DOWN         = 2'd2,
        RELEASE_WAIT = 2'd3
    } key_state_e;

    localparam int DEFAULT_DEBOUNCE_CYCLES = 2_000_000;
    localparam int DEFAULT_LONG_CYCLES     = 100_000_000;

endpackage

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous board inputs; both
// flops reset to RESET_VALUE so an idle pin produces no edge after reset.
`timescale 1ns/1ps
module sync_2ff #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic sync1_d, sync1_q;
    logic sync2_d, sync2_q;

    always_comb begin
        sync1_d = d;
        sync2_d = sync1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= RESET_VALUE;
            sync2_q <= RESET_VALUE;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
        end
    end

    assign q = sync2_q;

endmodule

// File: rtl/key_debounce.sv
// Push-button conditioner: synchronises KEY0, debounces press and release,
// and produces press/release/long-press pulses plus a short-press toggle.
`timescale 1ns/1ps
module key_debounce
    import bk_key_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_CYCLES     = DEFAULT_LONG_CYCLES,
    parameter int KEY_ACTIVE_LOW  = 1,
    parameter int RUN_INIT        = 1
) (
    input  logic CLK100MHZ,
    input  logic RESET_N,
    input  logic KEY0,
    output logic key_down,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse,
    output logic run
);

    localparam int DCW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int LCW = $clog2(LONG_CYCLES) + 1;
    localparam logic [DCW-1:0] D_LAST = DCW'(DEBOUNCE_CYCLES - 1);
    localparam logic [LCW-1:0] L_LAST = LCW'(LONG_CYCLES - 1);
    localparam logic ACTIVE_LOW_BIT = (KEY_ACTIVE_LOW != 0);
    localparam logic RUN_INIT_BIT   = (RUN_INIT != 0);

    key_state_e     state_d, state_q;
    logic [DCW-1:0] dcnt_d, dcnt_q;
    logic [LCW-1:0] lcnt_d, lcnt_q;
    logic           long_done_d, long_done_q;
    logic           key_down_d, key_down_q;
    logic           press_pulse_d, press_pulse_q;
    logic           release_pulse_d, release_pulse_q;
    logic           long_pulse_d, long_pulse_q;
    logic           run_d, run_q;
    logic           key_sync;
    logic           pressed;
    logic           long_fire;

    // Synchroniser idles at the released pin level so reset never looks like a press.
    sync_2ff #(
        .RESET_VALUE(ACTIVE_LOW_BIT)
    ) u_sync (
        .clk  (CLK100MHZ),
        .rst_n(RESET_N),
        .d    (KEY0),
        .q    (key_sync)
    );

    assign pressed = key_sync ^ ACTIVE_LOW_BIT;

    always_comb begin
        state_d         = state_q;
        dcnt_d          = dcnt_q;
        lcnt_d          = lcnt_q;
        long_done_d     = long_done_q;
        key_down_d      = key_down_q;
        run_d           = run_q;
        press_pulse_d   = 1'b0;
        release_pulse_d = 1'b0;
        long_pulse_d    = 1'b0;
        long_fire       = 1'b0;

        // Long-press timer runs through release bounces; the FSM below may override lcnt.
        if ((state_q == DOWN || state_q == RELEASE_WAIT) && !long_done_q) begin
            if (lcnt_q == L_LAST) begin
                long_fire    = 1'b1;
                long_pulse_d = 1'b1;
                long_done_d  = 1'b1;
            end else if (lcnt_q != '1) begin
                lcnt_d = lcnt_q + LCW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (pressed) begin
                    state_d = PRESS_WAIT;
                    dcnt_d  = '0;
                end
            end
            PRESS_WAIT: begin
                if (!pressed) begin
                    state_d = IDLE;
                end else if (dcnt_q == D_LAST) begin
                    state_d       = DOWN;
                    press_pulse_d = 1'b1;
                    key_down_d    = 1'b1;
                    lcnt_d        = '0;
                end else if (dcnt_q != '1) begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            DOWN: begin
                if (!pressed) begin
                    state_d = RELEASE_WAIT;
                    dcnt_d  = '0;
                end
            end
            RELEASE_WAIT: begin
                if (pressed) begin
                    state_d = DOWN;
                end else if (dcnt_q == D_LAST) begin
                    state_d         = IDLE;
                    release_pulse_d = 1'b1;
                    key_down_d      = 1'b0;
                    lcnt_d          = '0;
                    long_done_d     = 1'b0;
                    // A long press that matures on the release edge still counts as long.
                    if (!long_done_q && !long_fire) begin
                        run_d = !run_q;
                    end
                end else if (dcnt_q != '1) begin
                    dcnt_d = dcnt_q + DCW'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK100MHZ or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q         <= IDLE;
            dcnt_q          <= '0;
            lcnt_q          <= '0;
            long_done_q     <= 1'b0;
            key_down_q      <= 1'b0;
            press_pulse_q   <= 1'b0;
            release_pulse_q <= 1'b0;
            long_pulse_q    <= 1'b0;
            run_q           <= RUN_INIT_BIT;
        end else begin
            state_q         <= state_d;
            dcnt_q          <= dcnt_d;
            lcnt_q          <= lcnt_d;
            long_done_q     <= long_done_d;
            key_down_q      <= key_down_d;
            press_pulse_q   <= press_pulse_d;
            release_pulse_q <= release_pulse_d;
            long_pulse_q    <= long_pulse_d;
            run_q           <= run_d;
        end
    end

    assign key_down      = key_down_q;
    assign press_pulse   = press_pulse_q;
    assign release_pulse = release_pulse_q;
    assign long_pulse    = long_pulse_q;
    assign run           = run_q;

endmodule
